// File: rtl/ca_generation_stepper.sv
// ca_generation_stepper
// Advances a 1-D elementary cellular automaton by one generation per synchronised
// rising edge of a slow tick (or per step pulse while paused). The next row is
// built one cell per clock in a shadow register. It is committed to the visible
// row only while vblank is high, so the display never shows a partly updated row.
module ca_generation_stepper #(
  parameter int               WIDTH = 80,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH/2),
  parameter int               GENW  = 16
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             tick_in,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       rule,
  input  logic             vblank,
  output logic [WIDTH-1:0] row,
  output logic [GENW-1:0]  gen_count,
  output logic             busy,
  output logic             updated
);

  localparam int            IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic             tick_edge;
  logic             req;
  logic             start;
  logic             commit;
  logic             pending;
  logic [7:0]       rule_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_l;
  logic [IW-1:0]    idx_r;
  logic             cell_nx;
  logic [WIDTH-1:0] next_row;

  // tick_in is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= tick_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tick_edge = sync2 & ~sync3;
  // A tick only counts while running; a step only counts while paused
  assign req       = (tick_edge & run) | (step & ~run);

  // Single-entry request latch; starting a generation wins over a new request
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= 1'b0;
    end else if (req) begin
      pending <= 1'b1;
    end else begin
      pending <= pending;
    end
  end

  // Next-state logic and the start/commit strobes that steer the datapath
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_nx = COMPUTE;
          start    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      COMPUTE: begin
        if (idx == LAST) begin
          state_nx = COMMIT;
        end else begin
          state_nx = COMPUTE;
        end
      end
      COMMIT: begin
        if (vblank) begin
          state_nx = IDLE;
          commit   = 1'b1;
        end else begin
          state_nx = COMMIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Toroidal neighbour lookup: the left edge wraps to cell 0, the right edge to WIDTH-1
  always_comb begin
    idx_l   = (idx == LAST) ? IW'(0) : idx + IW'(1);
    idx_r   = (idx == IW'(0)) ? LAST : idx - IW'(1);
    cell_nx = rule_q[{row[idx_l], row[idx], row[idx_r]}];
  end

  // Shadow row: rule is frozen at start, then one cell is produced per clock
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      rule_q   <= 8'd0;
      idx      <= IW'(0);
      next_row <= {WIDTH{1'b0}};
    end else if (start) begin
      rule_q   <= rule;
      idx      <= IW'(0);
      next_row <= next_row;
    end else if (state == COMPUTE) begin
      rule_q        <= rule_q;
      idx           <= idx + IW'(1);
      next_row[idx] <= cell_nx;
    end else begin
      rule_q   <= rule_q;
      idx      <= idx;
      next_row <= next_row;
    end
  end

  // Visible row, generation counter and the post-commit pulse
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      row       <= SEED;
      gen_count <= {GENW{1'b0}};
      updated   <= 1'b0;
    end else if (commit) begin
      row       <= next_row;
      gen_count <= gen_count + {{(GENW-1){1'b0}}, 1'b1};
      updated   <= 1'b1;
    end else begin
      row       <= row;
      gen_count <= gen_count;
      updated   <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ca_generation_stepper.sv
// Bench for ca_generation_stepper: directed stimulus, scoreboard queues filled
// when a generation is requested, and monitors that pop on each updated pulse.
module tb_ca_generation_stepper;

  localparam int          W     = 80;
  localparam logic [79:0] SEED1 = 80'h1 << 40;
  localparam logic [79:0] G1    = (80'h1 << 39) | (80'h1 << 41);
  localparam logic [79:0] G2    = (80'h1 << 38) | (80'h1 << 42);
  localparam logic [79:0] G3    = (80'h1 << 37) | (80'h1 << 39) | (80'h1 << 41) | (80'h1 << 43);
  localparam logic [79:0] G4    = (80'h1 << 36) | (80'h1 << 44);
  localparam logic [79:0] G5    = (80'h1 << 35) | (80'h1 << 37) | (80'h1 << 43) | (80'h1 << 45);
  localparam logic [79:0] G6    = (80'h1 << 34) | (80'h1 << 38) | (80'h1 << 42) | (80'h1 << 46);

  typedef struct packed {
    logic [79:0] r;
    logic [15:0] g;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        tick;
  logic        run;
  logic        step;
  logic [7:0]  rule;
  logic        vblank;
  logic [79:0] row1;
  logic [15:0] gen1;
  logic        busy1;
  logic        upd1;

  logic        tick2;
  logic        run2;
  logic        step2;
  logic [7:0]  rule2;
  logic        vblank2;
  logic [7:0]  row2;
  logic [1:0]  gen2;
  logic        busy2;
  logic        upd2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks;
  int   errors;
  int   upd_cnt1;

  ca_generation_stepper dut1 (
    .clk_in(clk), .rstn(rstn), .tick_in(tick), .run(run), .step(step),
    .rule(rule), .vblank(vblank), .row(row1), .gen_count(gen1),
    .busy(busy1), .updated(upd1)
  );

  ca_generation_stepper #(.WIDTH(8), .SEED(8'h01), .GENW(2)) dut2 (
    .clk_in(clk), .rstn(rstn), .tick_in(tick2), .run(run2), .step(step2),
    .rule(rule2), .vblank(vblank2), .row(row2), .gen_count(gen2),
    .busy(busy2), .updated(upd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step2;
    step2 = 1'b1;
    cyc(1);
    step2 = 1'b0;
    cyc(14);
  endtask

  // Monitor for the 80-cell instance
  always @(negedge clk) begin
    if (rstn && upd1) begin
      exp_t e;
      upd_cnt1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon1_unexpected_update: got row %h gen %0d, expected no update", row1, gen1);
      end else begin
        e = q1.pop_front();
        chk("mon1_row", row1, e.r);
        chk("mon1_gen", {64'd0, gen1}, {64'd0, e.g});
      end
    end
  end

  // Monitor for the 8-cell instance
  always @(negedge clk) begin
    if (rstn && upd2) begin
      exp_t e;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon2_unexpected_update: got row %h gen %0d, expected no update", row2, gen2);
      end else begin
        e = q2.pop_front();
        chk("mon2_row", {72'd0, row2}, e.r);
        chk("mon2_gen", {78'd0, gen2}, {64'd0, e.g});
      end
    end
  end

  initial begin
    checks = 0; errors = 0; upd_cnt1 = 0;
    clk = 1'b0; rstn = 1'b0;
    tick = 1'b0; run = 1'b1; step = 1'b0; rule = 8'd90; vblank = 1'b1;
    tick2 = 1'b0; run2 = 1'b0; step2 = 1'b0; rule2 = 8'd30; vblank2 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_row", row1, SEED1);
    chk("rst_gen", {64'd0, gen1}, 80'd0);
    chk("rst_busy", {79'd0, busy1}, 80'd0);
    chk("rst_updated", {79'd0, upd1}, 80'd0);
    chk("rst_row2", {72'd0, row2}, 80'h01);
    @(posedge clk); #1 rstn = 1'b1;
    cyc(3);

    // Rule 90 from the centre seed, minimum latency W+5 clocks
    q1.push_back({G1, 16'd1});
    tick = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    chk("t1_row_before", row1, SEED1);
    chk("t1_busy_commit", {79'd0, busy1}, 80'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t1_row_after", row1, G1);
    chk("t1_gen", {64'd0, gen1}, 80'd1);
    chk("t1_busy_after", {79'd0, busy1}, 80'd0);
    cyc(5);
    chk("t1_one_update", 80'(upd_cnt1), 80'd1);
    tick = 1'b0;
    cyc(10);

    // Commit held off by vblank=0; rule change mid-generation ignored
    vblank = 1'b0;
    q1.push_back({G2, 16'd2});
    tick = 1'b1;
    cyc(20);
    rule = 8'd30;
    cyc(W + 10);
    chk("t3_busy_wait", {79'd0, busy1}, 80'd1);
    cyc(500);
    chk("t3_row_held", row1, G1);
    chk("t3_busy_held", {79'd0, busy1}, 80'd1);
    chk("t3_gen_held", {64'd0, gen1}, 80'd1);
    vblank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_row_commit", row1, G2);
    chk("t3_busy_fall", {79'd0, busy1}, 80'd0);
    rule = 8'd90;
    tick = 1'b0;
    cyc(10);

    // Paused: tick edges ignored, double step gives one generation
    run = 1'b0;
    tick = 1'b1; cyc(10); tick = 1'b0; cyc(10); tick = 1'b1; cyc(10);
    chk("t4_paused_gen", {64'd0, gen1}, 80'd2);
    chk("t4_paused_row", row1, G2);
    q1.push_back({G3, 16'd3});
    step = 1'b1; cyc(2); step = 1'b0;
    cyc(W + 10);
    chk("t4_step_gen", {64'd0, gen1}, 80'd3);
    chk("t4_step_row", row1, G3);
    run = 1'b1;
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(W + 10);
    chk("t4_step_running_ignored", {64'd0, gen1}, 80'd3);

    // Pausing mid-generation still completes it
    tick = 1'b0; cyc(10);
    q1.push_back({G4, 16'd4});
    tick = 1'b1; cyc(20);
    run = 1'b0;
    cyc(W + 10);
    chk("t4_pause_mid_gen", {64'd0, gen1}, 80'd4);
    chk("t4_pause_mid_row", row1, G4);
    run = 1'b1;

    // Two tick edges inside one generation: exactly one more afterwards
    tick = 1'b0; cyc(10);
    q1.push_back({G5, 16'd5});
    q1.push_back({G6, 16'd6});
    tick = 1'b1; cyc(20);
    tick = 1'b0; cyc(10);
    tick = 1'b1;
    cyc(2 * W + 20);
    chk("t5_gen", {64'd0, gen1}, 80'd6);
    chk("t5_row", row1, G6);

    // Narrow instance: wrap across the row edge, then counter wrap at GENW=2
    q2.push_back({80'h83, 16'd1});
    pulse_step2;
    chk("t2_wrap_row", {72'd0, row2}, 80'h83);
    q2.push_back({80'h46, 16'd2});
    pulse_step2;
    rule2 = 8'd0;
    q2.push_back({80'h00, 16'd3});
    pulse_step2;
    rule2 = 8'd255;
    q2.push_back({80'hFF, 16'd0});
    pulse_step2;
    chk("t5_genw_wrap", {78'd0, gen2}, 80'd0);
    chk("t5_row_ff", {72'd0, row2}, 80'hFF);

    // Asynchronous reset mid-generation discards the shadow row
    tick = 1'b0; cyc(10);
    tick = 1'b1; cyc(30);
    chk("t6_busy_before", {79'd0, busy1}, 80'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_row_async", row1, SEED1);
    chk("t6_gen_async", {64'd0, gen1}, 80'd0);
    chk("t6_busy_async", {79'd0, busy1}, 80'd0);
    tick = 1'b0;
    cyc(5);
    rstn = 1'b1;
    cyc(W + 20);
    chk("t6_row_after", row1, SEED1);
    chk("t6_no_update", 80'(upd_cnt1), 80'd6);
    chk("q1_drained", 80'(q1.size()), 80'd0);
    chk("q2_drained", 80'(q2.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
